// File: rtl/rst_sequencer.sv
// rst_sequencer: staged peripheral/core reset release, gated by synchronized PLL lock
// and a debounced active-low button, with a saturating lock-loss counter.
module rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_CYCLES     = 1024,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 18000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             btn_n,
  output logic             rst_periph,
  output logic             rst_core,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] lock_loss_cnt
);
  localparam int SEQ_MAX = LOCK_CYCLES > GAP_CYCLES ? LOCK_CYCLES : GAP_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, GAP, RUN} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] lock_sync, btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic [SEQ_W-1:0] seq_cnt, seq_cnt_nx;
  logic lock_s, btn_s, btn_db, pressed, loss;
  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign btn_s   = btn_sync[SYNC_STAGES-1];
  assign pressed = !btn_db;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n};
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  // Lock loss outranks the button so a simultaneous press still counts as a loss.
  always_comb begin
    state_nx = state;
    loss     = 1'b0;
    if (state == WAIT_LOCK) state_nx = (lock_s && !pressed) ? STABLE : WAIT_LOCK;
    else if (!lock_s) begin
      loss     = state == GAP || state == RUN;
      state_nx = WAIT_LOCK;
    end
    else if (pressed) state_nx = WAIT_LOCK;
    else if (state == STABLE && seq_cnt == SEQ_W'(LOCK_CYCLES)) state_nx = GAP;
    else if (state == GAP && seq_cnt == SEQ_W'(GAP_CYCLES - 1)) state_nx = RUN;
    seq_cnt_nx = (state_nx != state || state == WAIT_LOCK) ? '0 :
                 state == RUN ? seq_cnt : seq_cnt + SEQ_W'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= WAIT_LOCK;
      seq_cnt       <= '0;
      rst_periph    <= 1'b1;
      rst_core      <= 1'b1;
      ready         <= 1'b0;
      lock_lost     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= state_nx;
      seq_cnt    <= seq_cnt_nx;
      rst_periph <= state_nx == WAIT_LOCK || state_nx == STABLE;
      rst_core   <= state_nx != RUN;
      ready      <= state_nx == RUN;
      if (loss) begin
        lock_lost <= 1'b1;
        if (lock_loss_cnt != '1) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      end
    end
endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly downstream of the PLL wrapper and runs on the PLL output clock.
- Consumes the raw, asynchronous PLL lock indicator and a raw active-low reset button.
- Produces a staged, clean reset for the design:
  - peripheral reset (UART, timers, GPIO) releases first;
  - after a fixed gap, the RV32I core reset releases.
- Any PLL lock loss or button press returns the design to reset. Lock-loss events are counted for debug.

Parameters:
- SYNC_STAGES, 2, flop depth of the pll_lock and btn_n synchronizers (minimum 2).
- LOCK_CYCLES, 1024, consecutive synchronized-lock cycles required before peripheral reset releases (minimum 1).
- GAP_CYCLES, 16, cycles between rst_periph and rst_core deassertion (minimum 1).
- DEBOUNCE_CYCLES, 18000, stable cycles needed to accept a new button level (1 ms at 18 MHz).
- CNT_W, 8, width of lock_loss_cnt.

Ports:
- clk  in  1  PLL output clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset; asserts and releases the whole block.
- pll_lock  in  1  raw PLL lock, asynchronous to clk.
- btn_n  in  1  raw reset button, active-low, asynchronous, bouncing.
- rst_periph  out  1  active-high peripheral reset, registered.
- rst_core  out  1  active-high core reset, registered.
- ready  out  1  high only in RUN.
- lock_lost  out  1  sticky flag; set on lock loss in GAP or RUN.
- lock_loss_cnt  out  CNT_W  saturating count of those lock losses.

Behaviour:
- Reset (rst=1, asynchronous):
  - rst_periph=1, rst_core=1, ready=0, lock_lost=0, lock_loss_cnt=0.
  - State = WAIT_LOCK. All counters = 0.
  - Synchronizer flops = 0 for lock, 1 for btn.
  - Debounced button = released.
- Synchronizers:
  - lock_s is pll_lock through SYNC_STAGES flops.
  - btn_s is btn_n through SYNC_STAGES flops.
- Debounce:
  - While btn_s differs from the debounced level, the counter increments every cycle.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level adopts btn_s and the counter clears.
  - Any cycle with btn_s equal to the debounced level clears the counter.
  - pressed = debounced level is low.
- State machine (registered Moore outputs, updated on the same edge as the state):
  - WAIT_LOCK: rst_periph=1, rst_core=1, ready=0. Go to STABLE when lock_s=1 and not pressed; counter cleared.
  - STABLE: resets held. Counter increments each cycle.
    - After LOCK_CYCLES cycles in STABLE, go to GAP.
    - lock_s=0 returns to WAIT_LOCK; this is not counted as a loss.
  - GAP: rst_periph=0, rst_core=1. After GAP_CYCLES cycles in GAP, go to RUN.
  - RUN: rst_periph=0, rst_core=0, ready=1. Remains here indefinitely.
- Latency:
  - rst_periph falls exactly SYNC_STAGES+LOCK_CYCLES+1 edges after the first edge that samples pll_lock=1. This assumes pll_lock is held high, the button is released, and the state is WAIT_LOCK.
  - rst_core and ready change exactly GAP_CYCLES edges after rst_periph falls.
- Lock loss:
  - lock_s=0 in GAP or RUN goes to WAIT_LOCK on the next edge, with both resets asserted and ready=0 on that edge.
  - On the same edge, lock_loss_cnt increments and lock_lost is set.
  - lock_loss_cnt saturates at 2^CNT_W-1 and never wraps.
  - lock_lost and lock_loss_cnt clear only on rst.
- Button:
  - The edge on which pressed becomes 1, in any state, goes to WAIT_LOCK with both resets asserted.
  - While pressed=1, the block stays in WAIT_LOCK.
  - Button resets do not affect lock_loss_cnt.
- Priority: rst > lock loss > button > normal advance.
  - Lock loss and a press on the same edge count as a lock loss.
- Glitch rules:
  - A pll_lock pulse shorter than one clk may be missed; no requirement on it.
  - A lock drop during STABLE restarts the full LOCK_CYCLES count.
- rst asserted mid-sequence: all outputs return to reset values immediately (asynchronously), regardless of state.

Test Plan:
- LOCK_CYCLES=8, GAP_CYCLES=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=5; release rst, raise pll_lock at edge 0 -> rst_periph falls at edge 11; rst_core falls and ready rises at edge 15; lock_loss_cnt=0.
- Same setup; drop pll_lock for 3 cycles at edge 6, then hold high -> no deassertion; rst_periph falls 11 edges after the lock re-rise edge.
- In RUN, drop pll_lock -> both resets high and ready=0 by the 3rd edge after the drop; lock_lost=1, lock_loss_cnt=1. Relock -> full sequence repeats.
- CNT_W=2; force 5 lock losses from RUN -> lock_loss_cnt reads 1,2,3,3,3; assert rst -> cnt=0, lock_lost=0.
- In RUN, bounce btn_n low/high every 2 cycles for 20 cycles, then hold high -> ready stays 1. Then hold btn_n low 10 cycles -> resets assert 2+5+1 edges after the low; both stay asserted until btn_n is released and debounced, then the sequence restarts.
- Assert rst asynchronously mid-GAP (between clk edges) -> rst_periph=1 immediately, without waiting for a clock edge; state is WAIT_LOCK after release.
